eq_gain_scheduler: RTL and testbench
====================================

// Module: eq_gain_scheduler
// PURPOSE
// - Owns the ten band-gain registers that drive the 10-band FIR equalizer (gain_1..gain_10).
// - Host writes per-band target gains over a valid/ready port.
// - On each audio sample tick, live gains are stepped toward targets by at most STEP per tick
//   (anti-zipper ramp). One band is updated per clk, so a full sweep takes 10 cycles.
// PARAMETERS
// - GAIN_WIDTH  13     width of each unsigned gain word (matches equalizer gain ports)
// - STEP        16     max per-tick change of a live gain (unsigned, 1..2^GAIN_WIDTH-1)
// - RESET_GAIN  1024   reset value of every live and target gain
// PORTS
// - clk          in   1           system clock; all logic on rising edge
// - rst          in   1           synchronous reset, active-high
// - sample_tick  in   1           one-cycle pulse per audio sample; starts a ramp sweep
// - cfg_valid    in   1           host write request
// - cfg_ready    out  1           scheduler can accept a write this cycle
// - cfg_band     in   4           band index 0..9 (0 -> gain_1 ... 9 -> gain_10)
// - cfg_gain     in   GAIN_WIDTH  new target gain, unsigned
// - mute         in   1           soft-mute request (used only with EQ_SOFT_MUTE_EN)
// - gain_1..gain_10  out GAIN_WIDTH  live gains to equalizer, registered
// - settled      out  1           all live gains equal their effective targets, FSM idle
// - sweep_done   out  1           one-cycle pulse after band 9 is updated
// - cfg_err      out  1           one-cycle pulse: write accepted with cfg_band > 9
// - overrun      out  1           one-cycle pulse: sample_tick arrived during SCAN
// BEHAVIOUR
// - Reset (rst=1 at clk edge): live[i] = tgt[i] = RESET_GAIN; state = IDLE; idx = 0;
//   cfg_ready = 1; settled = 1; sweep_done = cfg_err = overrun = 0. Reset mid-sweep aborts the sweep.
// - FSM states: IDLE, SCAN.
//   - IDLE: sample_tick -> SCAN, idx = 0, cfg_ready = 0 next cycle.
//   - SCAN: each cycle update live[idx], then idx++. When idx = 9, go to IDLE next cycle
//     with idx = 0, pulse sweep_done and set cfg_ready = 1.
//   - A sweep is therefore exactly 10 SCAN cycles.
// - Ramp rule (per band, unsigned): e = effective target, d = |e - live|.
//   - d <= STEP: live = e.
//   - else: live = live + STEP if e > live, else live - STEP.
//   - Compute in GAIN_WIDTH+1 bits; no wrap, never overshoots e.
// - Handshake: write accepted when cfg_valid & cfg_ready (IDLE only).
//   - Accepted, band <= 9: tgt[band] = cfg_gain next cycle; live is untouched until the next sweep.
//   - Accepted, band > 9: no state change; cfg_err pulses next cycle.
// - Simultaneous accepted write and sample_tick in IDLE: the write lands first, so the sweep
//   ramps toward the new target.
// - sample_tick during SCAN: ignored (sweep not restarted), overrun pulses next cycle.
// - settled is registered and recomputed every cycle: 1 iff state = IDLE and live[i] == e[i] for all i.
// - gain_N outputs are the live registers directly; they change only during SCAN or reset.
// CONFIGURATION
// - EQ_SOFT_MUTE_EN defined: effective target e[i] = mute ? 0 : tgt[i].
//   - tgt[] is preserved while muted.
//   - Releasing mute ramps back to tgt[] at STEP per tick.
//   - Writes while muted update tgt[] only.
// - EQ_SOFT_MUTE_EN undefined: e[i] = tgt[i]; the mute port is present but ignored.
// TESTING
// - Reset, then idle 5 cycles -> all gain_N = 1024, settled = 1, cfg_ready = 1, pulses 0.
// - Write band 2 := 1100, then 3 sample_ticks 20 cycles apart -> gain_3 = 1040, 1056, 1072
//   on successive sweeps (STEP 16); others stay 1024; settled = 0.
// - Write band 0 := 1030, one tick -> gain_1 = 1030 exact (no overshoot); sweep_done
//   pulses 11 cycles after the tick; settled = 1.
// - Write cfg_band = 12, gain 0 -> cfg_err pulse, all gains unchanged;
//   cfg_valid during SCAN -> cfg_ready = 0, write held until IDLE.
// - Second sample_tick 4 cycles into a sweep -> overrun pulse, sweep still ends on band 9, single sweep_done.
// - With EQ_SOFT_MUTE_EN: mute=1 with all gains 1024, 64 ticks -> all gains 0; mute=0,
//   64 ticks -> all back to 1024. Without the macro, mute has no effect.

Source files
------------

// File: rtl/eq_gain_scheduler_if.sv
// Host/equalizer-facing bundle of the gain scheduler: config handshake, tick, mute and live gains.
interface eq_gain_scheduler_if #(
    parameter int GAIN_WIDTH = 13
);
    logic                  sample_tick;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [3:0]            cfg_band;
    logic [GAIN_WIDTH-1:0] cfg_gain;
    logic                  mute;
    logic [GAIN_WIDTH-1:0] gain_1, gain_2, gain_3, gain_4, gain_5;
    logic [GAIN_WIDTH-1:0] gain_6, gain_7, gain_8, gain_9, gain_10;
    logic                  settled;
    logic                  sweep_done;
    logic                  cfg_err;
    logic                  overrun;

    modport master (
        output sample_tick, cfg_valid, cfg_band, cfg_gain, mute,
        input  cfg_ready, settled, sweep_done, cfg_err, overrun,
        input  gain_1, gain_2, gain_3, gain_4, gain_5,
        input  gain_6, gain_7, gain_8, gain_9, gain_10
    );

    modport slave (
        input  sample_tick, cfg_valid, cfg_band, cfg_gain, mute,
        output cfg_ready, settled, sweep_done, cfg_err, overrun,
        output gain_1, gain_2, gain_3, gain_4, gain_5,
        output gain_6, gain_7, gain_8, gain_9, gain_10
    );
endinterface

// File: rtl/eq_gain_scheduler.sv
// Ten-band gain scheduler: host sets targets, each sample tick ramps live gains by at most STEP.
// Optional soft mute (effective target forced to 0) is enabled by defining EQ_SOFT_MUTE_EN.
module eq_gain_scheduler #(
    parameter int GAIN_WIDTH = 13,
    parameter int STEP       = 16,
    parameter int RESET_GAIN = 1024
) (
    input logic               clk,
    input logic               rst,
    eq_gain_scheduler_if.slave bus
);
    localparam int         NUM_BANDS = 10;
    localparam logic [3:0] LAST_BAND = 4'd9;
    localparam logic [GAIN_WIDTH-1:0] RESET_VAL = GAIN_WIDTH'(RESET_GAIN);
    localparam logic [GAIN_WIDTH:0]   STEP_X    = (GAIN_WIDTH+1)'(STEP);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [GAIN_WIDTH-1:0] liveGain_q [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] tgtGain_q  [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] effTgt     [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] liveNext;
    logic                  settled_q, sweepDone_q, cfgErr_q, overrun_q;
    logic                  cfgReady, scanEn, lastBand, cfgAccept, bandValid, allMatch;

    // Extended by one bit so the distance never wraps and the result never passes the target.
    function automatic logic [GAIN_WIDTH-1:0] rampStep(input logic [GAIN_WIDTH-1:0] live,
                                                        input logic [GAIN_WIDTH-1:0] tgt);
        logic [GAIN_WIDTH:0] liveX, tgtX;
        liveX = {1'b0, live};
        tgtX  = {1'b0, tgt};
        if (tgtX > liveX)
            rampStep = (tgtX - liveX <= STEP_X) ? tgt : GAIN_WIDTH'(liveX + STEP_X);
        else
            rampStep = (liveX - tgtX <= STEP_X) ? tgt : GAIN_WIDTH'(liveX - STEP_X);
    endfunction

`ifdef EQ_SOFT_MUTE_EN
    always_comb begin
        for (int i = 0; i < NUM_BANDS; i++)
            effTgt[i] = bus.mute ? '0 : tgtGain_q[i];
    end
`else
    logic unusedMute;
    assign unusedMute = bus.mute;

    always_comb begin
        for (int i = 0; i < NUM_BANDS; i++)
            effTgt[i] = tgtGain_q[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.sample_tick) state_d = SCAN;
            end
            SCAN: begin
                if (idx_q == LAST_BAND) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        cfgReady = (state_q == IDLE);
        scanEn   = (state_q == SCAN);
        lastBand = scanEn && (idx_q == LAST_BAND);
    end

    assign cfgAccept = bus.cfg_valid && cfgReady;
    assign bandValid = (bus.cfg_band <= LAST_BAND);
    assign liveNext  = rampStep(liveGain_q[idx_q], effTgt[idx_q]);

    always_comb begin
        allMatch = 1'b1;
        for (int i = 0; i < NUM_BANDS; i++)
            if (liveGain_q[i] != effTgt[i]) allMatch = 1'b0;
    end

    // A write and a tick in the same IDLE cycle both land here; the sweep reads the new target.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                liveGain_q[i] <= RESET_VAL;
                tgtGain_q[i]  <= RESET_VAL;
            end
            settled_q   <= 1'b1;
            sweepDone_q <= 1'b0;
            cfgErr_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            settled_q   <= !scanEn && allMatch;
            sweepDone_q <= lastBand;
            cfgErr_q    <= cfgAccept && !bandValid;
            overrun_q   <= scanEn && bus.sample_tick;
            if (cfgAccept && bandValid) tgtGain_q[bus.cfg_band] <= bus.cfg_gain;
            if (scanEn) liveGain_q[idx_q] <= liveNext;
        end
    end

    assign bus.cfg_ready  = cfgReady;
    assign bus.settled    = settled_q;
    assign bus.sweep_done = sweepDone_q;
    assign bus.cfg_err    = cfgErr_q;
    assign bus.overrun    = overrun_q;
    assign bus.gain_1     = liveGain_q[0];
    assign bus.gain_2     = liveGain_q[1];
    assign bus.gain_3     = liveGain_q[2];
    assign bus.gain_4     = liveGain_q[3];
    assign bus.gain_5     = liveGain_q[4];
    assign bus.gain_6     = liveGain_q[5];
    assign bus.gain_7     = liveGain_q[6];
    assign bus.gain_8     = liveGain_q[7];
    assign bus.gain_9     = liveGain_q[8];
    assign bus.gain_10    = liveGain_q[9];
endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Scoreboard bench for eq_gain_scheduler: each output pulse is matched against a queued expectation.
module tb_eq_gain_scheduler;
    localparam int GW = 13;
    localparam logic [1:0] KIND_SWEEP = 2'd0;
    localparam logic [1:0] KIND_ERR   = 2'd1;
    localparam logic [1:0] KIND_OVR   = 2'd2;

    typedef struct packed {
        logic [1:0]          kind;
        logic                chkSettled;
        logic                settled;
        logic [9:0][GW-1:0]  gains;
    } expItem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    expItem_t           expQ [$];
    logic [9:0][GW-1:0] expGains;
    logic [9:0][GW-1:0] actGains;
    logic               settledPending = 1'b0;
    logic               settledExp = 1'b0;

    eq_gain_scheduler_if #(.GAIN_WIDTH(GW)) bus ();

    eq_gain_scheduler #(.GAIN_WIDTH(GW), .STEP(16), .RESET_GAIN(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign actGains[0] = bus.gain_1;
    assign actGains[1] = bus.gain_2;
    assign actGains[2] = bus.gain_3;
    assign actGains[3] = bus.gain_4;
    assign actGains[4] = bus.gain_5;
    assign actGains[5] = bus.gain_6;
    assign actGains[6] = bus.gain_7;
    assign actGains[7] = bus.gain_8;
    assign actGains[8] = bus.gain_9;
    assign actGains[9] = bus.gain_10;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [1:0] kind, input logic chk, input logic st);
        expItem_t item;
        item.kind       = kind;
        item.chkSettled = chk;
        item.settled    = st;
        item.gains      = expGains;
        expQ.push_back(item);
    endtask

    task automatic checkEvent(input logic [1:0] kind, input string name);
        expItem_t item;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected %s: got pulse expected none", name);
        end else begin
            item = expQ.pop_front();
            checkOutput({name, " kind"}, int'(kind), int'(item.kind));
            for (int b = 0; b < 10; b++)
                checkOutput($sformatf("%s gain_%0d", name, b + 1),
                            int'(actGains[b]), int'(item.gains[b]));
            if (item.chkSettled) begin
                settledPending = 1'b1;
                settledExp     = item.settled;
            end
        end
    endtask

    // Monitor: settled is checked one cycle after sweep_done because it is registered.
    always @(negedge clk) begin
        if (settledPending) begin
            settledPending = 1'b0;
            checkOutput("settled after sweep", int'(bus.settled), int'(settledExp));
        end
        if (!rst) begin
            if (bus.sweep_done) checkEvent(KIND_SWEEP, "sweep_done");
            if (bus.cfg_err)    checkEvent(KIND_ERR, "cfg_err");
            if (bus.overrun)    checkEvent(KIND_OVR, "overrun");
        end
    end

    task automatic applyStimulus(input bit doWrite, input logic [3:0] band,
                                 input logic [GW-1:0] gain, input bit doTick);
        int waitCnt;
        @(negedge clk);
        bus.cfg_valid   = doWrite;
        bus.cfg_band    = band;
        bus.cfg_gain    = gain;
        bus.sample_tick = doTick;
        waitCnt = 0;
        while (doWrite && !bus.cfg_ready && waitCnt < 200) begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
            waitCnt++;
        end
        if (waitCnt >= 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL cfg handshake: got ready=0 for 200 cycles expected ready=1");
        end
        @(negedge clk);
        bus.cfg_valid   = 1'b0;
        bus.sample_tick = 1'b0;
    endtask

    task automatic tickAndWait(input logic st);
        pushExp(KIND_SWEEP, 1'b1, st);
        applyStimulus(1'b0, 4'd0, '0, 1'b1);
        repeat (14) @(negedge clk);
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.cfg_valid   = 1'b0;
        bus.cfg_band    = '0;
        bus.cfg_gain    = '0;
        bus.mute        = 1'b0;
        for (int b = 0; b < 10; b++) expGains[b] = 13'd1024;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] reset state");
        for (int b = 0; b < 10; b++) checkOutput($sformatf("reset gain_%0d", b + 1), int'(actGains[b]), 1024);
        checkOutput("reset settled", int'(bus.settled), 1);
        checkOutput("reset cfg_ready", int'(bus.cfg_ready), 1);
        checkOutput("reset pulses", int'({bus.sweep_done, bus.cfg_err, bus.overrun}), 0);

        $display("[TB] band 0 -> 1030, no overshoot, sweep_done latency");
        applyStimulus(1'b1, 4'd0, 13'd1030, 1'b0);
        expGains[0] = 13'd1030;
        pushExp(KIND_SWEEP, 1'b1, 1'b1);
        @(negedge clk);
        bus.sample_tick = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            bus.sample_tick = 1'b0;
            cnt++;
        end while (!bus.sweep_done && cnt < 50);
        checkOutput("sweep_done latency", cnt, 11);
        repeat (14) @(negedge clk);

        $display("[TB] band 2 -> 1100 ramp");
        applyStimulus(1'b1, 4'd2, 13'd1100, 1'b0);
        expGains[2] = 13'd1040; pushExp(KIND_SWEEP, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, '0, 1'b1); repeat (19) @(negedge clk);
        expGains[2] = 13'd1056; pushExp(KIND_SWEEP, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, '0, 1'b1); repeat (19) @(negedge clk);
        expGains[2] = 13'd1072; pushExp(KIND_SWEEP, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, '0, 1'b1); repeat (19) @(negedge clk);
        expGains[2] = 13'd1088; tickAndWait(1'b0);
        expGains[2] = 13'd1100; tickAndWait(1'b1);

        $display("[TB] simultaneous write and tick");
        expGains[7] = 13'd1040;
        pushExp(KIND_SWEEP, 1'b1, 1'b0);
        applyStimulus(1'b1, 4'd7, 13'd1050, 1'b1);
        repeat (14) @(negedge clk);
        expGains[7] = 13'd1050; tickAndWait(1'b1);

        $display("[TB] out-of-range band");
        pushExp(KIND_ERR, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd12, 13'd0, 1'b0);
        repeat (4) @(negedge clk);
        tickAndWait(1'b1);

        $display("[TB] write held during scan");
        pushExp(KIND_SWEEP, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, '0, 1'b1);
        @(negedge clk);
        checkOutput("cfg_ready in scan", int'(bus.cfg_ready), 0);
        applyStimulus(1'b1, 4'd5, 13'd1000, 1'b0);
        repeat (4) @(negedge clk);
        expGains[5] = 13'd1008; tickAndWait(1'b0);
        expGains[5] = 13'd1000; tickAndWait(1'b1);

        $display("[TB] overrun");
        pushExp(KIND_OVR, 1'b0, 1'b0);
        pushExp(KIND_SWEEP, 1'b1, 1'b1);
        applyStimulus(1'b0, 4'd0, '0, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 4'd0, '0, 1'b1);
        repeat (25) @(negedge clk);

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, 4'd3, 13'd2000, 1'b0);
        applyStimulus(1'b0, 4'd0, '0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            expGains[b] = 13'd1024;
            checkOutput($sformatf("mid-reset gain_%0d", b + 1), int'(actGains[b]), 1024);
        end
        checkOutput("mid-reset cfg_ready", int'(bus.cfg_ready), 1);
        checkOutput("mid-reset settled", int'(bus.settled), 1);
        repeat (20) @(negedge clk);
        tickAndWait(1'b1);

`ifdef EQ_SOFT_MUTE_EN
        $display("[TB] soft mute down and back up");
        bus.mute = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            for (int b = 0; b < 10; b++) expGains[b] = GW'(1024 - 16 * k);
            tickAndWait(k == 64);
        end
        bus.mute = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            for (int b = 0; b < 10; b++) expGains[b] = GW'(16 * k);
            tickAndWait(k == 64);
        end
`else
        $display("[TB] mute ignored");
        bus.mute = 1'b1;
        tickAndWait(1'b1);
        bus.mute = 1'b0;
`endif

        repeat (5) @(negedge clk);
        checkOutput("pending expectations", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
